gb_uart_loader: RTL and testbench

- Serial-side writer for the cartridge/BIOS image load path.
- Receives 8N1 UART bytes from the host PC and parses a framed packet protocol.
- Drives uart_addr/uart_data_in/uart_we/uart_load into the Game Boy memory controller, which routes writes by uart_addr[27:24]: 0 = ROM, 1 = BIOS, 2 = JBIOS.
- Sits between the board UART RX pin and the memory controller.

---
 rtl/gb_uart_loader.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_gb_uart_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_uart_loader.sv
// UART-fed image loader: receives 8N1 bytes, parses A5-framed START/WRITE/END packets
// and streams payload bytes into the Game Boy memory controller write port.
module gb_uart_loader #(
    parameter int CLKS_PER_BIT = 217,
    parameter int TIMEOUT_CLKS = 2500000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        uart_rx,
    output logic [27:0] uart_addr,
    output logic [7:0]  uart_data_in,
    output logic        uart_we,
    output logic        uart_load,
    output logic        busy,
    output logic        pkt_done,
    output logic        csum_err,
    output logic        frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMO_M1  = TW'(TIMEOUT_CLKS - 1);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_START = 8'h10;
    localparam logic [7:0] CMD_WRITE = 8'h11;
    localparam logic [7:0] CMD_END   = 8'h12;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {P_SYNC, P_CMD, P_ADDR, P_LEN, P_DATA, P_CSUM} p_state_t;

    // ------------------------------------------------------------------ RX
    logic            sync1_q, sync2_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_ferr_q, rx_ferr_d;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (!sync2_q) begin
                    rx_state_d = R_START;
                    cnt_d      = '0;
                end
            end
            R_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d      = '0;
                    bit_idx_d  = '0;
                    rx_state_d = sync2_q ? R_IDLE : R_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = R_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d      = '0;
                    rx_state_d = R_IDLE;
                    if (sync2_q) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = shift_q;
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            // NOTE: synchroniser resets to the idle line level so reset release cannot fake a start bit.
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_state_q <= R_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            sync1_q    <= uart_rx;
            sync2_q    <= sync1_q;
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    // -------------------------------------------------------------- parser
    p_state_t      p_state_q, p_state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [2:0]    idx_q, idx_d;
    logic [27:0]   ptr_q, ptr_d;
    logic [15:0]   len_q, len_d;
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [27:0]   uart_addr_q, uart_addr_d;
    logic [7:0]    uart_data_q, uart_data_d;
    logic          we_pend_q, we_pend_d;
    logic          uart_we_q, uart_we_d;
    logic          uart_load_q, uart_load_d;
    logic          end_pend_q, end_pend_d;
    logic          busy_q, busy_d;
    logic          pkt_done_q, pkt_done_d;
    logic          csum_err_q, csum_err_d;
    logic          frame_err_q, frame_err_d;

    always_comb begin
        p_state_d   = p_state_q;
        cmd_d       = cmd_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        csum_d      = csum_q;
        tmo_d       = tmo_q;
        uart_addr_d = uart_addr_q;
        uart_data_d = uart_data_q;
        we_pend_d   = 1'b0;
        uart_we_d   = we_pend_q & uart_load_q;
        uart_load_d = uart_load_q;
        end_pend_d  = 1'b0;
        pkt_done_d  = 1'b0;
        csum_err_d  = csum_err_q;
        frame_err_d = frame_err_q;

        if (end_pend_q) begin
            uart_load_d = 1'b0;
        end

        // Idle watchdog: only runs mid-packet, restarted by every received byte.
        if (p_state_q == P_SYNC || rx_valid_q) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_M1) begin
            tmo_d     = '0;
            p_state_d = P_SYNC;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (rx_ferr_q) begin
            frame_err_d = 1'b1;
            p_state_d   = P_SYNC;
        end else if (rx_valid_q) begin
            if (p_state_q != P_SYNC && p_state_q != P_CSUM) begin
                csum_d = csum_q + rx_data_q;
            end
            case (p_state_q)
                P_SYNC: begin
                    if (rx_data_q == SYNC_BYTE) begin
                        p_state_d = P_CMD;
                        csum_d    = '0;
                    end
                end
                P_CMD: begin
                    cmd_d = rx_data_q;
                    idx_d = '0;
                    case (rx_data_q)
                        CMD_START, CMD_END: p_state_d = P_CSUM;
                        CMD_WRITE:          p_state_d = P_ADDR;
                        default:            p_state_d = P_SYNC;
                    endcase
                end
                P_ADDR: begin
                    case (idx_q)
                        3'd0:    ptr_d[27:24] = rx_data_q[3:0];
                        3'd1:    ptr_d[23:16] = rx_data_q;
                        3'd2:    ptr_d[15:8]  = rx_data_q;
                        default: ptr_d[7:0]   = rx_data_q;
                    endcase
                    if (idx_q == 3'd3) begin
                        idx_d     = '0;
                        p_state_d = P_LEN;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                P_LEN: begin
                    if (idx_q == 3'd0) begin
                        len_d[15:8] = rx_data_q;
                        idx_d       = 3'd1;
                    end else begin
                        len_d[7:0] = rx_data_q;
                        p_state_d  = ({len_q[15:8], rx_data_q} == 16'd0) ? P_CSUM : P_DATA;
                    end
                end
                P_DATA: begin
                    uart_data_d = rx_data_q;
                    uart_addr_d = ptr_q;
                    we_pend_d   = uart_load_q;
                    ptr_d       = ptr_q + 28'd1;
                    len_d       = len_q - 16'd1;
                    if (len_q == 16'd1) begin
                        p_state_d = P_CSUM;
                    end
                end
                P_CSUM: begin
                    p_state_d = P_SYNC;
                    if (rx_data_q == csum_q) begin
                        pkt_done_d = 1'b1;
                        if (cmd_q == CMD_START) begin
                            uart_load_d = 1'b1;
                            csum_err_d  = 1'b0;
                            frame_err_d = 1'b0;
                        end else if (cmd_q == CMD_END) begin
                            end_pend_d = 1'b1;
                        end
                    end else begin
                        csum_err_d = 1'b1;
                    end
                end
                default: p_state_d = P_SYNC;
            endcase
        end

        busy_d = (p_state_d != P_SYNC);
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            p_state_q   <= P_SYNC;
            cmd_q       <= '0;
            idx_q       <= '0;
            ptr_q       <= '0;
            len_q       <= '0;
            csum_q      <= '0;
            tmo_q       <= '0;
            uart_addr_q <= '0;
            uart_data_q <= '0;
            we_pend_q   <= 1'b0;
            uart_we_q   <= 1'b0;
            uart_load_q <= 1'b0;
            end_pend_q  <= 1'b0;
            busy_q      <= 1'b0;
            pkt_done_q  <= 1'b0;
            csum_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            p_state_q   <= p_state_d;
            cmd_q       <= cmd_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            csum_q      <= csum_d;
            tmo_q       <= tmo_d;
            uart_addr_q <= uart_addr_d;
            uart_data_q <= uart_data_d;
            we_pend_q   <= we_pend_d;
            uart_we_q   <= uart_we_d;
            uart_load_q <= uart_load_d;
            end_pend_q  <= end_pend_d;
            busy_q      <= busy_d;
            pkt_done_q  <= pkt_done_d;
            csum_err_q  <= csum_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign uart_addr    = uart_addr_q;
    assign uart_data_in = uart_data_q;
    assign uart_we      = uart_we_q;
    assign uart_load    = uart_load_q;
    assign busy         = busy_q;
    assign pkt_done     = pkt_done_q;
    assign csum_err     = csum_err_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_gb_uart_loader.sv
// Self-checking bench for gb_uart_loader: packet vector table plus hand-written
// sequences for framing errors, glitches, timeout, END timing and async reset.
module tb_gb_uart_loader;

    localparam int CPB = 8;
    localparam int TMO = 400;

    logic        clock;
    logic        rst;
    logic        uart_rx;
    logic [27:0] uart_addr;
    logic [7:0]  uart_data_in;
    logic        uart_we;
    logic        uart_load;
    logic        busy;
    logic        pkt_done;
    logic        csum_err;
    logic        frame_err;

    gb_uart_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
        .clock        (clock),
        .rst          (rst),
        .uart_rx      (uart_rx),
        .uart_addr    (uart_addr),
        .uart_data_in (uart_data_in),
        .uart_we      (uart_we),
        .uart_load    (uart_load),
        .busy         (busy),
        .pkt_done     (pkt_done),
        .csum_err     (csum_err),
        .frame_err    (frame_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    // Monitor: write log, lag between data update and strobe, pkt_done/load timing.
    logic [27:0] we_addr[$];
    logic [7:0]  we_data[$];
    int          we_lag[$];
    int          we_cnt = 0;
    int          done_cnt = 0;
    int          we_no_load = 0;
    int          since_chg = 0;
    logic [27:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;
    logic        load_at_done = 1'b0;
    logic        load_after_done = 1'b0;
    logic        after_done = 1'b0;

    always @(negedge clock) begin
        if (uart_addr != prev_addr || uart_data_in != prev_data) since_chg = 0;
        else since_chg++;
        prev_addr = uart_addr;
        prev_data = uart_data_in;
        if (after_done) begin
            load_after_done = uart_load;
            after_done = 1'b0;
        end
        if (uart_we) begin
            we_cnt++;
            if (!uart_load) we_no_load++;
            we_addr.push_back(uart_addr);
            we_data.push_back(uart_data_in);
            we_lag.push_back(since_chg);
        end
        if (pkt_done) begin
            done_cnt++;
            load_at_done = uart_load;
            after_done = 1'b1;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clock);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clock);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clock);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [15:0] len;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic        bad_csum;
        int          exp_done;
        int          exp_we;
        logic [27:0] exp_a0;
        logic [27:0] exp_a1;
        logic        exp_load;
        logic        exp_cerr;
    } vec_t;

    task automatic send_packet(input vec_t v);
        logic [7:0] body[$];
        logic [7:0] cs;
        body.push_back(v.cmd);
        if (v.cmd == 8'h11) begin
            body.push_back(v.addr[31:24]);
            body.push_back(v.addr[23:16]);
            body.push_back(v.addr[15:8]);
            body.push_back(v.addr[7:0]);
            body.push_back(v.len[15:8]);
            body.push_back(v.len[7:0]);
            if (v.len > 16'd0) body.push_back(v.d0);
            if (v.len > 16'd1) body.push_back(v.d1);
        end
        cs = 8'h00;
        foreach (body[i]) cs = cs + body[i];
        if (v.bad_csum) cs = cs + 8'h01;
        send_byte(8'hA5, 1'b1);
        foreach (body[i]) send_byte(body[i], 1'b1);
        send_byte(cs, 1'b1);
        repeat (4) @(negedge clock);
    endtask

    task automatic clear_log();
        we_addr.delete();
        we_data.delete();
        we_lag.delete();
    endtask

    vec_t vecs[11];
    vec_t v;
    int   d_start;
    int   w_start;

    initial begin
        vecs[0]  = '{8'h10, 32'h0,        16'd0, 8'h00, 8'h00, 1'b0, 1, 0, 28'h0,       28'h0,       1'b1, 1'b0};
        vecs[1]  = '{8'h11, 32'h01000100, 16'd2, 8'h3C, 8'h7E, 1'b0, 1, 2, 28'h1000100, 28'h1000101, 1'b1, 1'b0};
        vecs[2]  = '{8'h11, 32'h01000100, 16'd2, 8'h3C, 8'h7E, 1'b1, 0, 2, 28'h1000100, 28'h1000101, 1'b1, 1'b1};
        vecs[3]  = '{8'h10, 32'h0,        16'd0, 8'h00, 8'h00, 1'b0, 1, 0, 28'h0,       28'h0,       1'b1, 1'b0};
        vecs[4]  = '{8'h11, 32'hFFFFFFFF, 16'd2, 8'hAA, 8'h55, 1'b0, 1, 2, 28'hFFFFFFF, 28'h0000000, 1'b1, 1'b0};
        vecs[5]  = '{8'h11, 32'h02000010, 16'd0, 8'h00, 8'h00, 1'b0, 1, 0, 28'h0,       28'h0,       1'b1, 1'b0};
        vecs[6]  = '{8'h13, 32'h0,        16'd0, 8'h00, 8'h00, 1'b0, 0, 0, 28'h0,       28'h0,       1'b1, 1'b0};
        vecs[7]  = '{8'h12, 32'h0,        16'd0, 8'h00, 8'h00, 1'b0, 1, 0, 28'h0,       28'h0,       1'b0, 1'b0};
        vecs[8]  = '{8'h11, 32'h00000020, 16'd1, 8'h5A, 8'h00, 1'b0, 1, 0, 28'h0,       28'h0,       1'b0, 1'b0};
        vecs[9]  = '{8'h10, 32'h0,        16'd0, 8'h00, 8'h00, 1'b1, 0, 0, 28'h0,       28'h0,       1'b0, 1'b1};
        vecs[10] = '{8'h10, 32'h0,        16'd0, 8'h00, 8'h00, 1'b0, 1, 0, 28'h0,       28'h0,       1'b1, 1'b0};

        rst = 1'b0;
        uart_rx = 1'b1;
        repeat (5) @(negedge clock);
        check("rst_addr", 32'(uart_addr), 32'h0);
        check("rst_data", 32'(uart_data_in), 32'h0);
        check("rst_flags", {26'd0, uart_we, uart_load, busy, pkt_done, csum_err, frame_err}, 32'h0);
        rst = 1'b1;
        repeat (5) @(negedge clock);

        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
            d_start = done_cnt;
            w_start = we_cnt;
            clear_log();
            send_packet(v);
            check($sformatf("v%0d_done", i), 32'(done_cnt - d_start), 32'(v.exp_done));
            check($sformatf("v%0d_we", i), 32'(we_cnt - w_start), 32'(v.exp_we));
            check($sformatf("v%0d_load", i), 32'(uart_load), 32'(v.exp_load));
            check($sformatf("v%0d_cerr", i), 32'(csum_err), 32'(v.exp_cerr));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'h0);
            if (v.exp_we > 0 && we_addr.size() > 0) begin
                check($sformatf("v%0d_a0", i), 32'(we_addr[0]), 32'(v.exp_a0));
                check($sformatf("v%0d_d0", i), 32'(we_data[0]), 32'(v.d0));
                check($sformatf("v%0d_lag0", i), 32'(we_lag[0]), 32'd1);
            end
            if (v.exp_we > 1 && we_addr.size() > 1) begin
                check($sformatf("v%0d_a1", i), 32'(we_addr[1]), 32'(v.exp_a1));
                check($sformatf("v%0d_d1", i), 32'(we_data[1]), 32'(v.d1));
                check($sformatf("v%0d_lag1", i), 32'(we_lag[1]), 32'd1);
            end
            if (v.cmd == 8'h12 && v.exp_done == 1) begin
                check("end_load_at_done", 32'(load_at_done), 32'h1);
                check("end_load_after_done", 32'(load_after_done), 32'h0);
            end
        end

        // Framing error inside the address field, then a clean WRITE.
        w_start = we_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (10) @(negedge clock);
        check("ferr_flag", 32'(frame_err), 32'h1);
        check("ferr_busy", 32'(busy), 32'h0);
        check("ferr_no_we", 32'(we_cnt - w_start), 32'h0);
        clear_log();
        d_start = done_cnt;
        v = '{8'h11, 32'h01000200, 16'd1, 8'hC3, 8'h00, 1'b0, 1, 1, 28'h1000200, 28'h0, 1'b1, 1'b0};
        send_packet(v);
        check("ferr_next_done", 32'(done_cnt - d_start), 32'h1);
        check("ferr_next_we", 32'(we_addr.size()), 32'h1);
        if (we_addr.size() > 0) begin
            check("ferr_next_addr", 32'(we_addr[0]), 32'h1000200);
            check("ferr_next_data", 32'(we_data[0]), 32'hC3);
        end
        check("ferr_sticky", 32'(frame_err), 32'h1);

        // Short low glitch between sync and cmd must not become a byte.
        d_start = done_cnt;
        send_byte(8'hA5, 1'b1);
        uart_rx = 1'b0;
        repeat (2) @(negedge clock);
        uart_rx = 1'b1;
        repeat (40) @(negedge clock);
        send_byte(8'h10, 1'b1);
        send_byte(8'h10, 1'b1);
        repeat (4) @(negedge clock);
        check("glitch_done", 32'(done_cnt - d_start), 32'h1);
        check("glitch_ferr_clr", 32'(frame_err), 32'h0);

        // Stall mid-payload until the watchdog fires.
        w_start = we_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h99, 1'b1);
        repeat (10) @(negedge clock);
        check("tmo_busy_before", 32'(busy), 32'h1);
        check("tmo_we", 32'(we_cnt - w_start), 32'h1);
        repeat (TMO + 20) @(negedge clock);
        check("tmo_busy_after", 32'(busy), 32'h0);
        check("tmo_load_kept", 32'(uart_load), 32'h1);

        // END closes the session.
        v = '{8'h12, 32'h0, 16'd0, 8'h00, 8'h00, 1'b0, 1, 0, 28'h0, 28'h0, 1'b0, 1'b0};
        send_packet(v);
        check("end_load", 32'(uart_load), 32'h0);

        // Asynchronous reset in the middle of a payload byte.
        v = '{8'h10, 32'h0, 16'd0, 8'h00, 8'h00, 1'b0, 1, 0, 28'h0, 28'h0, 1'b1, 1'b0};
        send_packet(v);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h11, 1'b1);
        check("pre_rst_addr", 32'(uart_addr), 32'h400);
        check("pre_rst_load", 32'(uart_load), 32'h1);
        uart_rx = 1'b0;
        repeat (12) @(negedge clock);
        #2 rst = 1'b0;
        #1;
        check("arst_addr", 32'(uart_addr), 32'h0);
        check("arst_data", 32'(uart_data_in), 32'h0);
        check("arst_flags", {26'd0, uart_we, uart_load, busy, pkt_done, csum_err, frame_err}, 32'h0);
        uart_rx = 1'b1;
        repeat (10) @(negedge clock);
        rst = 1'b1;
        repeat (10) @(negedge clock);
        d_start = done_cnt;
        send_packet(v);
        check("post_rst_done", 32'(done_cnt - d_start), 32'h1);
        check("post_rst_load", 32'(uart_load), 32'h1);
        check("we_without_load", 32'(we_no_load), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
